// File: rtl/game_pkg.sv
// Shared constants and types for the game datapath, control FSM and bench.
package game_pkg;

    // Game-level durations in seconds, used by the control FSM and the bench.
    localparam int COUNTDOWN_MAX = 5;
    localparam int GAME_TIME_MAX = 30;

    // Datapath widths.
    localparam int SEC_W   = 6;
    localparam int SCORE_W = 8;

    // Control FSM state encoding, shared so debug/state outputs decode identically everywhere.
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_COUNTDOWN = 2'd1,
        ST_PLAYING   = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_t;

endpackage

// File: rtl/game_timebase_score_sec_counter.sv
// Whole-second counter with its own prescaler. Clear beats enable; with
// enable low the partial second is held. Saturates at SEC_MAX, where the
// prescaler keeps wrapping but neither sec nor tick moves.
module sec_counter
    import game_pkg::*;
#(
    parameter int TICK_CYCLES = 100000000,
    parameter int SEC_MAX     = 63
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             clear,
    output logic [SEC_W-1:0] sec,
    output logic             tick
);

    localparam int               PRE_W    = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);
    localparam logic [SEC_W-1:0] SEC_LAST = SEC_W'(SEC_MAX);

    logic [PRE_W-1:0] r_pre;
    logic [SEC_W-1:0] r_sec;
    logic             r_tick;
    logic             w_wrap;
    logic             w_sec_inc;

    // A second completes when an enabled cycle finds the prescaler on its last count.
    assign w_wrap    = enable && (r_pre == PRE_LAST);
    assign w_sec_inc = w_wrap && (r_sec != SEC_LAST);

    // Prescaler, seconds register and the registered tick that aligns with the new sec value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pre  <= '0;
            r_sec  <= '0;
            r_tick <= 1'b0;
        end else if (clear) begin
            r_pre  <= '0;
            r_sec  <= '0;
            r_tick <= 1'b0;
        end else if (enable) begin
            r_pre  <= w_wrap ? '0 : r_pre + PRE_W'(1);
            r_sec  <= w_sec_inc ? r_sec + SEC_W'(1) : r_sec;
            r_tick <= w_sec_inc;
        end else begin
            r_tick <= 1'b0;
        end
    end

    assign sec  = r_sec;
    assign tick = r_tick;

endmodule

// File: rtl/game_timebase_score.sv
// Game datapath: countdown and game-time second counters plus a saturating
// two-digit BCD score, all driven by level enable/clear strobes from the FSM.
module game_timebase_score
    import game_pkg::*;
#(
    parameter int                 TICK_CYCLES   = 100000000,
    parameter int                 SEC_MAX       = 63,
    parameter logic [SCORE_W-1:0] SCORE_MAX_BCD = 8'h99
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable_countdown,
    input  logic               clear_countdown,
    input  logic               enable_game_timer,
    input  logic               clear_game_timer,
    input  logic               enable_score,
    input  logic               clear_score,
    input  logic               hit_pulse,
    input  logic               miss_pulse,
    output logic [SEC_W-1:0]   countdown_sec,
    output logic [SEC_W-1:0]   game_time_sec,
    output logic               game_sec_tick,
    output logic [SCORE_W-1:0] score
);

    logic               w_unused_countdown_tick;
    logic [SCORE_W-1:0] r_score;
    logic [SCORE_W-1:0] w_score_next;
    logic [3:0]         w_tens;
    logic [3:0]         w_ones;

    sec_counter #(
        .TICK_CYCLES (TICK_CYCLES),
        .SEC_MAX     (SEC_MAX)
    ) u_countdown (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable_countdown),
        .clear  (clear_countdown),
        .sec    (countdown_sec),
        .tick   (w_unused_countdown_tick)
    );

    sec_counter #(
        .TICK_CYCLES (TICK_CYCLES),
        .SEC_MAX     (SEC_MAX)
    ) u_game_time (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (enable_game_timer),
        .clear  (clear_game_timer),
        .sec    (game_time_sec),
        .tick   (game_sec_tick)
    );

    assign w_tens = r_score[7:4];
    assign w_ones = r_score[3:0];

    // Next score: clear first, then a lone hit or miss steps the BCD value,
    // saturating at SCORE_MAX_BCD going up and at 00 going down.
    always_comb begin
        w_score_next = r_score;
        if (clear_score) begin
            w_score_next = '0;
        end else if (enable_score && (hit_pulse != miss_pulse)) begin
            if (hit_pulse) begin
                if (r_score != SCORE_MAX_BCD) begin
                    if (w_ones == 4'd9) begin
                        w_score_next = {w_tens + 4'd1, 4'd0};
                    end else begin
                        w_score_next = {w_tens, w_ones + 4'd1};
                    end
                end
            end else begin
                if (r_score != '0) begin
                    if (w_ones == 4'd0) begin
                        w_score_next = {w_tens - 4'd1, 4'd9};
                    end else begin
                        w_score_next = {w_tens, w_ones - 4'd1};
                    end
                end
            end
        end
    end

    // Score register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_score <= '0;
        end else begin
            r_score <= w_score_next;
        end
    end

    assign score = r_score;

endmodule

// File: tb/tb_game_timebase_score.sv
// Bench for game_timebase_score with a 10-cycle second.
module tb_game_timebase_score;
    import game_pkg::*;

    localparam int TICK = 10;
    localparam int SMAX = 63;

    logic       clk;
    logic       rst_n;
    logic       enable_countdown;
    logic       clear_countdown;
    logic       enable_game_timer;
    logic       clear_game_timer;
    logic       enable_score;
    logic       clear_score;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [5:0] countdown_sec;
    logic [5:0] game_time_sec;
    logic       game_sec_tick;
    logic [7:0] score;

    int n_cmp;
    int n_bad;

    // Reference model: enabled-cycle counts since clear, and score as an integer.
    int m_cd_n;
    int m_gt_n;
    int m_score;
    bit m_tick;
    int tick_count;

    game_timebase_score #(
        .TICK_CYCLES   (TICK),
        .SEC_MAX       (SMAX),
        .SCORE_MAX_BCD (8'h99)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .enable_countdown  (enable_countdown),
        .clear_countdown   (clear_countdown),
        .enable_game_timer (enable_game_timer),
        .clear_game_timer  (clear_game_timer),
        .enable_score      (enable_score),
        .clear_score       (clear_score),
        .hit_pulse         (hit_pulse),
        .miss_pulse        (miss_pulse),
        .countdown_sec     (countdown_sec),
        .game_time_sec     (game_time_sec),
        .game_sec_tick     (game_sec_tick),
        .score             (score)
    );

    // Clock and reset block.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sec_of(input int n);
        int s;
        s = n / TICK;
        return (s > SMAX) ? SMAX : s;
    endfunction

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit en_cd, input bit clr_cd, input bit en_gt, input bit clr_gt,
                          input bit en_sc, input bit clr_sc, input bit hit, input bit miss);
        enable_countdown  = en_cd;
        clear_countdown   = clr_cd;
        enable_game_timer = en_gt;
        clear_game_timer  = clr_gt;
        enable_score      = en_sc;
        clear_score       = clr_sc;
        hit_pulse         = hit;
        miss_pulse        = miss;
    endtask

    // One clock: advance the model from the applied inputs, then compare all outputs.
    task automatic cycle();
        int old_gt;
        @(posedge clk);
        if (clear_countdown) m_cd_n = 0;
        else if (enable_countdown) m_cd_n++;
        old_gt = sec_of(m_gt_n);
        if (clear_game_timer) m_gt_n = 0;
        else if (enable_game_timer) m_gt_n++;
        m_tick = !clear_game_timer && (sec_of(m_gt_n) > old_gt);
        if (clear_score) m_score = 0;
        else if (enable_score && hit_pulse && !miss_pulse) m_score = (m_score < 99) ? m_score + 1 : 99;
        else if (enable_score && miss_pulse && !hit_pulse) m_score = (m_score > 0) ? m_score - 1 : 0;
        #1;
        if (game_sec_tick) tick_count++;
        check("countdown_sec", countdown_sec, sec_of(m_cd_n));
        check("game_time_sec", game_time_sec, sec_of(m_gt_n));
        check("game_sec_tick", game_sec_tick, m_tick);
        check("score", score, to_bcd(m_score));
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    typedef struct {
        bit         en;
        bit         clr;
        bit         hit;
        bit         miss;
        logic [7:0] exp;
    } score_vec_t;

    score_vec_t vecs[12];

    initial begin
        n_cmp = 0;
        n_bad = 0;
        m_cd_n = 0;
        m_gt_n = 0;
        m_score = 0;
        m_tick = 0;
        tick_count = 0;
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        check("reset_countdown", countdown_sec, 0);
        check("reset_game", game_time_sec, 0);
        check("reset_tick", game_sec_tick, 0);
        check("reset_score", score, 0);
        #11 rst_n = 1'b1;

        // Countdown: one clear cycle, then run; first second on the 10th enabled edge.
        set_in(0, 1, 0, 0, 0, 0, 0, 0);
        cycle();
        set_in(1, 0, 0, 0, 0, 0, 0, 0);
        cycles(9);
        check("cd_before_first", countdown_sec, 0);
        cycle();
        check("cd_first_sec", countdown_sec, 1);
        cycles(40);
        check("cd_after_50", countdown_sec, 5);
        check("gt_idle", game_time_sec, 0);

        // Game timer with a pause: partial second preserved.
        set_in(0, 0, 0, 1, 0, 0, 0, 0);
        cycle();
        tick_count = 0;
        set_in(0, 0, 1, 0, 0, 0, 0, 0);
        cycles(25);
        check("gt_at_pause", game_time_sec, 2);
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        cycles(7);
        check("gt_paused", game_time_sec, 2);
        set_in(0, 0, 1, 0, 0, 0, 0, 0);
        cycles(5);
        check("gt_resumed", game_time_sec, 3);
        check("gt_tick_count", tick_count, 3);

        // Clear and enable together at sec 4; next increment 10 cycles after clear drops.
        cycles(10);
        check("gt_at_4", game_time_sec, 4);
        set_in(0, 0, 1, 1, 0, 0, 0, 0);
        cycles(3);
        check("gt_clr_en", game_time_sec, 0);
        set_in(0, 0, 1, 0, 0, 0, 0, 0);
        cycles(9);
        check("gt_post_clr_9", game_time_sec, 0);
        cycle();
        check("gt_post_clr_10", game_time_sec, 1);
        check("gt_post_clr_tick", game_sec_tick, 1);

        // Saturation: 700 enabled cycles, exactly 63 ticks.
        set_in(0, 0, 0, 1, 0, 0, 0, 0);
        cycle();
        tick_count = 0;
        set_in(0, 0, 1, 0, 0, 0, 0, 0);
        cycles(700);
        check("gt_saturated", game_time_sec, 63);
        check("gt_sat_ticks", tick_count, 63);

        // Score table, applied from a cleared score.
        vecs[0]  = '{en: 1, clr: 1, hit: 0, miss: 0, exp: 8'h00};
        vecs[1]  = '{en: 1, clr: 0, hit: 1, miss: 0, exp: 8'h01};
        vecs[2]  = '{en: 1, clr: 0, hit: 1, miss: 0, exp: 8'h02};
        vecs[3]  = '{en: 1, clr: 0, hit: 0, miss: 1, exp: 8'h01};
        vecs[4]  = '{en: 1, clr: 0, hit: 1, miss: 1, exp: 8'h01};
        vecs[5]  = '{en: 0, clr: 0, hit: 1, miss: 0, exp: 8'h01};
        vecs[6]  = '{en: 0, clr: 0, hit: 0, miss: 1, exp: 8'h01};
        vecs[7]  = '{en: 1, clr: 0, hit: 0, miss: 1, exp: 8'h00};
        vecs[8]  = '{en: 1, clr: 0, hit: 0, miss: 1, exp: 8'h00};
        vecs[9]  = '{en: 1, clr: 0, hit: 1, miss: 0, exp: 8'h01};
        vecs[10] = '{en: 1, clr: 1, hit: 1, miss: 0, exp: 8'h00};
        vecs[11] = '{en: 1, clr: 0, hit: 1, miss: 0, exp: 8'h01};
        for (int i = 0; i < 12; i++) begin
            set_in(0, 0, 0, 0, vecs[i].en, vecs[i].clr, vecs[i].hit, vecs[i].miss);
            cycle();
            check($sformatf("score_vec%0d", i), score, vecs[i].exp);
        end

        // BCD carry/borrow and saturation sequences.
        set_in(0, 0, 0, 0, 1, 1, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 1, 0, 1, 0);
        cycles(9);
        check("score_09", score, 8'h09);
        cycle();
        check("score_10", score, 8'h10);
        set_in(0, 0, 0, 0, 1, 0, 0, 1);
        cycle();
        check("score_borrow", score, 8'h09);
        set_in(0, 0, 0, 0, 1, 1, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 1, 0, 1, 0);
        cycles(100);
        check("score_sat_99", score, 8'h99);
        cycles(3);
        check("score_hold_99", score, 8'h99);
        set_in(0, 0, 0, 0, 1, 1, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 1, 0, 0, 1);
        cycle();
        check("score_floor", score, 8'h00);

        // Random stimulus, checked every cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            set_in($urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0,
                   $urandom_range(0, 9) != 0, $urandom_range(0, 99) == 0,
                   $urandom_range(0, 7) != 0, $urandom_range(0, 199) == 0,
                   $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0);
            cycle();
        end

        // Asynchronous reset mid-count, then recount from zero.
        set_in(1, 0, 1, 0, 1, 0, 1, 0);
        cycles(17);
        #3 rst_n = 1'b0;
        #1;
        check("async_rst_cd", countdown_sec, 0);
        check("async_rst_gt", game_time_sec, 0);
        check("async_rst_tick", game_sec_tick, 0);
        check("async_rst_score", score, 0);
        m_cd_n = 0;
        m_gt_n = 0;
        m_score = 0;
        m_tick = 0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        set_in(1, 0, 1, 0, 0, 0, 0, 0);
        cycles(9);
        check("post_rst_9", game_time_sec, 0);
        cycle();
        check("post_rst_10", game_time_sec, 1);
        check("post_rst_cd", countdown_sec, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/game_timebase_score.md
Name: game_timebase_score

Overview:
- Slave-side datapath driven by the game control FSM's enable/clear strobes.
- Contains two independent seconds counters (countdown, game time) and one BCD score counter.
- Returns countdown_sec, game_time_sec and score to the FSM, and score to the display path.
- Turns the FSM's level-type enable/clear controls into accurate whole-second counts and a saturating two-digit BCD score.

Parameters:
- TICK_CYCLES, 100000000, clk cycles per second; the bench uses 10.
- SEC_MAX, 63, saturation value of both seconds counters; must fit 6 bits.
- SCORE_MAX_BCD, 8'h99, score saturation value in BCD.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable_countdown  in  1  countdown counter runs while high
- clear_countdown  in  1  synchronous clear of countdown counter and its prescaler
- enable_game_timer  in  1  game counter runs while high
- clear_game_timer  in  1  synchronous clear of game counter and its prescaler
- enable_score  in  1  gates hit/miss pulses
- clear_score  in  1  synchronous clear of score
- hit_pulse  in  1  one-cycle pulse, +1 score
- miss_pulse  in  1  one-cycle pulse, -1 score
- countdown_sec  out  6  whole seconds since countdown clear
- game_time_sec  out  6  whole seconds since game clear
- game_sec_tick  out  1  one-cycle pulse when game_time_sec increments
- score  out  8  BCD score, [7:4] tens, [3:0] ones

Behaviour:
- Reset and clock: reset rst_n, asynchronous, active-low; clock clk. In reset, all counters, prescalers and outputs are 0.
- Each seconds counter has its own prescaler, 0..TICK_CYCLES-1.
- Priority per cycle, highest first:
  - clear: prescaler and sec are set to 0; no tick.
  - enable: the prescaler increments. When the prescaler is at TICK_CYCLES-1, it wraps to 0 and sec increments on the same edge.
  - otherwise: hold (pause; the partial second is preserved).
- Clear and enable asserted together: clear wins. The FSM does this on state entry.
- The first increment occurs exactly TICK_CYCLES enabled cycles after clear deasserts.
- Saturation: at SEC_MAX, sec holds. The prescaler keeps wrapping but no increment occurs and no game_sec_tick is generated.
- game_sec_tick is registered and high in the same cycle game_time_sec shows the new value.
- Score update, registered, visible the cycle after the pulse:
  - clear_score → 8'h00, highest priority.
  - enable_score low → hit and miss are ignored.
  - hit only → BCD increment: ones 9 → 0 with tens+1; at 8'h99, hold.
  - miss only → BCD decrement: ones 0 → 9 with tens-1; at 8'h00, hold (no wrap).
  - hit and miss in the same cycle → no change.
- Score digits are always valid BCD (0-9 each); a non-BCD value must be unreachable.
- Counters are fully independent; activity on one never affects the other or the score.
- Reset mid-second: the prescaler is lost and counting restarts from 0 after release.

Decomposition:
- Shared package game_pkg holds:
  - COUNTDOWN_MAX = 5 and GAME_TIME_MAX = 30, used by the FSM and the bench.
  - SEC_W = 6 and SCORE_W = 8.
  - FSM state encoding (IDLE/COUNTDOWN/PLAYING/GAME_OVER).
- One sub-module, sec_counter (parameters TICK_CYCLES, SEC_MAX; ports clk, rst_n, enable, clear, sec, tick), instantiated twice.
- The BCD score logic stays inline in the top.

Test Plan:
- TICK_CYCLES=10. Clear 1 cycle, then enable continuously → countdown_sec = 1 on the 10th enabled edge, 5 after 50 cycles; game_time_sec stays 0.
- Enable game timer 25 cycles, drop enable 7 cycles, re-enable → game_time_sec = 2 at pause, unchanged during pause, 3 after 5 more enabled cycles. game_sec_tick is a single-cycle pulse per increment.
- Clear and enable asserted together for 3 cycles with the counter at 4 → sec = 0 and prescaler = 0. The next increment comes exactly 10 cycles after clear drops.
- Enable for 700 cycles → game_time_sec saturates at 63; no further game_sec_tick.
- Score, enable_score=1:
  - 9 hits → 8'h09; 1 more hit → 8'h10.
  - miss at 8'h10 → 8'h09.
  - 100 hits from 0 → 8'h99 and holds.
  - miss at 8'h00 → 8'h00.
- Hit and miss in the same cycle → unchanged.
- Hit with enable_score=0 → unchanged.
- Hit and clear_score together → 8'h00.
- rst_n asserted mid-count → all outputs 0 immediately (asynchronously).
